// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg
//   Shared types and constants for the PC / fetch-redirect unit.
//   pcu_state_e : fetch FSM states (IDLE, FETCH, WAIT, HALTED), 2-bit encoding.
//   PC_STEP     : sequential instruction stride in bytes.
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        PCU_IDLE   = 2'd0,
        PCU_FETCH  = 2'd1,
        PCU_WAIT   = 2'd2,
        PCU_HALTED = 2'd3
    } pcu_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_redirect_unit_flush_counter.sv
// flush_counter
//   Loadable down-counter; nonzero is high while the count is above zero.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   asynchronous reset, active-high (count -> 0)
//     load    in   load LOAD_VALUE at the next edge (wins over decrement)
//     nonzero out  count != 0
module flush_counter
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned LOAD_VALUE = 2,
    parameter int unsigned WIDTH      = $clog2(LOAD_VALUE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic nonzero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(LOAD_VALUE);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the fetch PC and the instruction-fetch request. Redirects fetch on
//   an EX-stage branch/jump, generates the wrong-path flush, and handles
//   load-use stalls, instruction-memory wait states and halt.
//   Optional build macro: PC_MISALIGN_TRAP_EN (misaligned redirect halts and
//   pulses misalign_o instead of being rounded down to a word address).
//   Ports:
//     clk, rst        clock / asynchronous active-high reset
//     stall_i         hold PC and IF/ID
//     branch_taken_i  qualified branch decision from EX
//     jump_i          JAL/JALR resolved in EX
//     target_i        redirect target from EX
//     halt_i          ECALL/EBREAK decoded in ID
//     imem_ready_i    instruction memory returns data this cycle
//     imem_req_o      fetch request at pc_o
//     pc_o            current fetch PC
//     pc_plus4_o      pc_o + 4 (combinational)
//     if_valid_o      IF/ID may capture the fetched instruction
//     flush_o         squash IF/ID and ID/EX
//     halted_o        fetch stopped until reset
//     misalign_o      (PC_MISALIGN_TRAP_EN only) one-cycle misaligned-target pulse
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            halt_i,
    input  logic            imem_ready_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            if_valid_o,
    output logic            flush_o,
    output logic            halted_o
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    pcu_state_e      state, state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_target;
    logic            redirect;
    logic            take_redirect;

    assign redirect      = branch_taken_i | jump_i;
    assign take_redirect = redirect && (state != PCU_HALTED);
    assign pc_plus4_o    = pc_o + XLEN'(PC_STEP);

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned      = (target_i[1:0] != 2'b00);
    assign redirect_target = target_i;
`else
    assign redirect_target = {target_i[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PCU_IDLE;
            pc_o  <= RESET_PC;
        end else begin
            state <= state_next;
            pc_o  <= pc_next;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= take_redirect && misaligned;
        end
    end
`endif

    // Normal FETCH/WAIT sequencing first, then redirect/halt override it,
    // which gives the redirect > halt > stall > advance priority.
    always_comb begin
        state_next = state;
        pc_next    = pc_o;
        imem_req_o = 1'b0;
        if_valid_o = 1'b0;
        halted_o   = 1'b0;

        case (state)
            PCU_IDLE: begin
                state_next = PCU_FETCH;
            end
            PCU_FETCH, PCU_WAIT: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    state_next = PCU_FETCH;
                    if (!stall_i) begin
                        if_valid_o = 1'b1;
                        pc_next    = pc_plus4_o;
                    end
                end else begin
                    state_next = PCU_WAIT;
                end
            end
            PCU_HALTED: begin
                halted_o = 1'b1;
            end
            default: begin
                state_next = PCU_IDLE;
            end
        endcase

        if (take_redirect) begin
            // A pending WAIT is simply abandoned: memory reads have no side effects.
            if_valid_o = 1'b0;
            state_next = PCU_FETCH;
            pc_next    = redirect_target;
`ifdef PC_MISALIGN_TRAP_EN
            if (misaligned) begin
                state_next = PCU_HALTED;
                pc_next    = pc_o;
            end
`endif
        end else if (halt_i && state != PCU_HALTED) begin
            state_next = PCU_HALTED;
            pc_next    = pc_o;
        end
    end

    flush_counter #(
        .LOAD_VALUE (FLUSH_CYCLES),
        .WIDTH      ($clog2(FLUSH_CYCLES + 1))
    ) u_flush_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (take_redirect),
        .nonzero (flush_o)
    );

endmodule
